// File: rtl/quant_scheduler_if.sv
// Block-offer / quantizer bundle for quant_scheduler.
// slave = scheduler view, master = producers + quantizer + zigzag view.
interface quant_scheduler_if #(
  parameter int MAX_INFLIGHT = 4
);
  localparam int CW = $clog2(MAX_INFLIGHT) + 1;

  typedef logic signed [10:0] coef_t;

  logic                 sched_en;
  logic [2:0]           blk_valid;
  logic [2:0]           blk_ready;
  coef_t [0:7][0:7]     y_blk;
  coef_t [0:7][0:7]     cb_blk;
  coef_t [0:7][0:7]     cr_blk;
  coef_t [0:7][0:7]     z_blk;
  logic                 quant_en;
  logic [1:0]           tbl_sel;
  logic                 quant_done;
  logic                 q_valid;
  logic [1:0]           q_chan;
  logic [CW-1:0]        inflight;
  logic                 idle;
  logic                 err;

  modport slave (
    input  sched_en,
    input  blk_valid,
    input  y_blk,
    input  cb_blk,
    input  cr_blk,
    input  quant_done,
    output blk_ready,
    output z_blk,
    output quant_en,
    output tbl_sel,
    output q_valid,
    output q_chan,
    output inflight,
    output idle,
    output err
  );

  modport master (
    output sched_en,
    output blk_valid,
    output y_blk,
    output cb_blk,
    output cr_blk,
    output quant_done,
    input  blk_ready,
    input  z_blk,
    input  quant_en,
    input  tbl_sel,
    input  q_valid,
    input  q_chan,
    input  inflight,
    input  idle,
    input  err
  );
endinterface

// File: rtl/quant_scheduler.sv
// Round-robin share of one quantizer between Y/Cb/Cr block producers.
// A channel-tag FIFO labels each quantizer result with its source.
module quant_scheduler #(
  parameter int QUANT_LATENCY = 4,
  parameter int MAX_INFLIGHT  = 4
) (
  input logic             clk,
  input logic             rst,
  quant_scheduler_if.slave bus
);
  localparam int AW = $clog2(MAX_INFLIGHT);
  localparam int CW = AW + 1;

  if (QUANT_LATENCY < 2) begin : g_lat_chk
    $error("QUANT_LATENCY must be at least 2");
  end

  if (MAX_INFLIGHT < 2 || MAX_INFLIGHT > 8 ||
      (MAX_INFLIGHT & (MAX_INFLIGHT - 1)) != 0) begin : g_mi_chk
    $error("MAX_INFLIGHT must be a power of 2 in 2..8");
  end

  typedef logic [0:7][0:7][10:0] blk_t;

  logic [1:0]    rr_ptr;
  logic [1:0]    win;
  logic          grant;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [2:0]    ready;
  blk_t          sel_blk;
  blk_t          z_q;
  logic          quant_en_q;
  logic [1:0]    tbl_sel_q;
  logic          err_q;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic [1:0]    tags [MAX_INFLIGHT];

  assign full  = (cnt == CW'(MAX_INFLIGHT));
  assign empty = (cnt == '0);

  // rst term keeps blk_ready low while reset is held
  assign grant = rst & bus.sched_en & ~full & (|bus.blk_valid);

  always_comb begin
    win = 2'd0;
    unique case (rr_ptr)
      2'd1: begin
        if (bus.blk_valid[1])      win = 2'd1;
        else if (bus.blk_valid[2]) win = 2'd2;
        else                       win = 2'd0;
      end
      2'd2: begin
        if (bus.blk_valid[2])      win = 2'd2;
        else if (bus.blk_valid[0]) win = 2'd0;
        else                       win = 2'd1;
      end
      default: begin
        if (bus.blk_valid[0])      win = 2'd0;
        else if (bus.blk_valid[1]) win = 2'd1;
        else                       win = 2'd2;
      end
    endcase
  end

  assign ready = grant ? (3'b001 << win) : 3'b000;
  assign push  = grant;
  assign pop   = bus.quant_done & ~empty;

  always_comb begin
    sel_blk = bus.y_blk;
    unique case (1'b1)
      ready[1]: sel_blk = bus.cb_blk;
      ready[2]: sel_blk = bus.cr_blk;
      default:  sel_blk = bus.y_blk;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr     <= 2'd0;
      z_q        <= '0;
      quant_en_q <= 1'b0;
      tbl_sel_q  <= 2'd0;
      err_q      <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      for (int i = 0; i < MAX_INFLIGHT; i++) begin
        tags[i] <= 2'd0;
      end
    end else begin
      quant_en_q <= push;
      if (push) begin
        z_q          <= sel_blk;
        tbl_sel_q    <= win;
        tags[wr_ptr] <= win;
        wr_ptr       <= wr_ptr + AW'(1);
        rr_ptr       <= (win == 2'd2) ? 2'd0 : win + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        cnt <= cnt + CW'(1);
      end else if (pop && !push) begin
        cnt <= cnt - CW'(1);
      end
      if (bus.quant_done && empty) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.blk_ready = ready;
  assign bus.z_blk     = z_q;
  assign bus.quant_en  = quant_en_q;
  assign bus.tbl_sel   = tbl_sel_q;
  assign bus.q_valid   = pop;
  assign bus.q_chan    = empty ? 2'd0 : tags[rd_ptr];
  assign bus.inflight  = cnt;
  assign bus.idle      = empty & ~quant_en_q;
  assign bus.err       = err_q;
endmodule
